alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Reservation station in front of the integer ALU.
- Receives decoded ALU/branch/jump/LUI/AUIPC ops from the dispatcher together with operand values or ROB tags.
- Snoops the ALU and LSB result broadcasts to wake pending operands.
- Each cycle, issues at most one ready op to the ALU as a registered single-cycle pulse, carrying the fields the ALU consumes.

Parameters:
- RS_SIZE, 16, number of entries; power of two.
- RS_ID_W, 4, log2(RS_SIZE).
- ROB_ID_W, 4, ROB tag width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; state frozen when low
- rollback  in  1  mispredict flush; synchronous
- in_valid  in  1  new op from dispatcher this cycle
- in_opcode  in  7  opcode
- in_func3  in  3  funct3
- in_func1  in  1  funct7[5]
- in_rs1_rdy  in  1  1 = in_rs1_val valid, 0 = wait on in_rs1_tag
- in_rs1_val  in  32  operand 1 value
- in_rs1_tag  in  ROB_ID_W  producer tag for operand 1
- in_rs2_rdy, in_rs2_val, in_rs2_tag  in  1/32/ROB_ID_W  same for operand 2
- in_imm  in  32  immediate
- in_off  in  32  branch/JAL offset
- in_pc  in  32  instruction PC
- in_rob_target  in  ROB_ID_W  destination ROB entry
- rs_full  out  1  all entries busy
- alu_res_valid  in  1  ALU broadcast valid
- alu_res_rob  in  ROB_ID_W  ALU broadcast tag
- alu_res_val  in  32  ALU broadcast value
- lsb_res_valid, lsb_res_rob, lsb_res_val  in  1/ROB_ID_W/32  LSB broadcast
- out_valid  out  1  op presented to ALU (ALU inst_valid)
- out_opcode, out_func3, out_func1  out  7/3/1
- out_data1, out_data2, out_imm, out_off, out_pc  out  32 each
- out_rob_target  out  ROB_ID_W

Behaviour:
- Reset / rollback:
  - On a clk edge with rst or rollback high, regardless of rdy: all busy bits cleared; out_valid and all out_* set to 0.
  - An in_valid in the same cycle is dropped.
  - rst/rollback dominate every other event.
- rdy low: no state change; outputs hold; in_valid and broadcasts that cycle are ignored.
- Entry state: busy, opcode, func3, func1, v1, q1_wait, q1, v2, q2_wait, q2, imm, off, pc, rob_target.
- rs_full: combinational, = AND of all busy bits. It is not relieved by a same-cycle dispatch.
- Allocation:
  - Condition: rdy & in_valid & !rs_full.
  - Entry written is the lowest-index non-busy entry.
  - in_valid while rs_full: op dropped. Dispatcher must never do this; assertion in bench.
- Issue forwarding:
  - If in_rsX_rdy=0 and a valid broadcast in the same cycle matches in_rsX_tag, the entry is written with that value and qX_wait=0.
  - If both ALU and LSB match, ALU wins.
- Wakeup:
  - Each busy entry with qX_wait and a matching valid broadcast captures the value and clears qX_wait at the edge.
  - Both operands may wake in the same cycle.
- Ready:
  - An entry is ready when busy & !q1_wait & !q2_wait, evaluated on registered state only.
  - An entry woken or allocated at edge k is eligible in the cycle after edge k.
- Dispatch (each rdy cycle):
  - Select the lowest-index ready entry. If one exists: out_valid<=1, out_* <= entry fields, busy<=0.
  - Otherwise out_valid<=0.
  - out_valid is therefore a one-cycle pulse per op; back-to-back ops give consecutive pulses.
- Simultaneous events:
  - Dispatch of entry i and allocation in the same cycle: allocation picks among entries non-busy before the edge, so never i.
  - Broadcast matching a dispatched entry's stale tag: impossible by construction (dispatched entries have no waits).
- Latency:
  - in_valid with both operands ready at cycle k → out_valid high in cycle k+2.
  - Waiting operand broadcast at cycle j → out_valid at j+2 at the earliest.
- Tag/rob widths and opcodes are passed through unmodified; no arithmetic performed here.

Test Plan:
- Ready passthrough: rst, then one cycle in_valid ADD, rs1_val=5, rs2_val=7, rob_target=3 → exactly two cycles later out_valid=1 for one cycle, out_data1=5, out_data2=7, out_rob_target=3; rs_full=0 throughout.
- Wakeup:
  - Issue SUB with rs1 tag 4 pending and rs2=1 → no out_valid.
  - Then alu_res_valid, rob=4, val=0x10 → out_valid two cycles later with out_data1=0x10.
  - Repeat via LSB broadcast.
- Issue-cycle forwarding: in_valid with in_rs2_tag=9 while lsb_res_valid, rob=9, val=0xABCD → dispatch in the same k+2 timing as a ready op, out_data2=0xABCD.
- Ordering and full:
  - Fill 16 entries all waiting on tag 2 → rs_full=1; a 17th in_valid is dropped.
  - Broadcast tag 2 → 16 consecutive out_valid pulses in entry-index order; rs_full drops the cycle after the first dispatch.
- Rollback mid-operation: 5 busy entries, rollback asserted coincident with in_valid and a ready entry → next cycle out_valid=0, rs_full=0, no later dispatch of any old op.
- rdy stall: hold rdy=0 for 3 cycles with a ready entry and a broadcast → no state change, broadcast lost; after rdy=1 behaviour resumes from the frozen state.

Source files
------------

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: holds ALU ops until their operands are ready, then issues the lowest-index ready op.
module alu_reservation_station #(
  parameter int RS_SIZE  = 16,
  parameter int RS_ID_W  = 4,
  parameter int ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                in_valid,
  input  logic [6:0]          in_opcode,
  input  logic [2:0]          in_func3,
  input  logic                in_func1,
  input  logic                in_rs1_rdy,
  input  logic [31:0]         in_rs1_val,
  input  logic [ROB_ID_W-1:0] in_rs1_tag,
  input  logic                in_rs2_rdy,
  input  logic [31:0]         in_rs2_val,
  input  logic [ROB_ID_W-1:0] in_rs2_tag,
  input  logic [31:0]         in_imm,
  input  logic [31:0]         in_off,
  input  logic [31:0]         in_pc,
  input  logic [ROB_ID_W-1:0] in_rob_target,
  output logic                rs_full,
  input  logic                alu_res_valid,
  input  logic [ROB_ID_W-1:0] alu_res_rob,
  input  logic [31:0]         alu_res_val,
  input  logic                lsb_res_valid,
  input  logic [ROB_ID_W-1:0] lsb_res_rob,
  input  logic [31:0]         lsb_res_val,
  output logic                out_valid,
  output logic [6:0]          out_opcode,
  output logic [2:0]          out_func3,
  output logic                out_func1,
  output logic [31:0]         out_data1,
  output logic [31:0]         out_data2,
  output logic [31:0]         out_imm,
  output logic [31:0]         out_off,
  output logic [31:0]         out_pc,
  output logic [ROB_ID_W-1:0] out_rob_target
);
  logic [RS_SIZE-1:0]  busy, q1_wait, q2_wait, ready;
  logic [6:0]          opcode [RS_SIZE];
  logic [2:0]          func3 [RS_SIZE];
  logic                func1 [RS_SIZE];
  logic [31:0]         v1 [RS_SIZE];
  logic [31:0]         v2 [RS_SIZE];
  logic [31:0]         imm [RS_SIZE];
  logic [31:0]         off [RS_SIZE];
  logic [31:0]         pc [RS_SIZE];
  logic [ROB_ID_W-1:0] q1 [RS_SIZE];
  logic [ROB_ID_W-1:0] q2 [RS_SIZE];
  logic [ROB_ID_W-1:0] rob_target [RS_SIZE];
  logic [32:0]         w1 [RS_SIZE];
  logic [32:0]         w2 [RS_SIZE];
  logic [32:0]         s1, s2;
  logic [RS_ID_W-1:0]  free_idx, sel_idx;
  logic                has_ready;
  // {hit, value}: ALU broadcast takes priority over LSB when both carry the tag
  function automatic logic [32:0] snoop(input logic [ROB_ID_W-1:0] t);
    return (alu_res_valid && alu_res_rob == t) ? {1'b1, alu_res_val} :
           (lsb_res_valid && lsb_res_rob == t) ? {1'b1, lsb_res_val} : 33'd0;
  endfunction
  assign ready     = busy & ~q1_wait & ~q2_wait;
  assign rs_full   = &busy;
  assign has_ready = |ready;
  assign s1        = snoop(in_rs1_tag);
  assign s2        = snoop(in_rs2_tag);
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = RS_ID_W'(i);
      if (ready[i]) sel_idx = RS_ID_W'(i);
    end
  end
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w1[i] = snoop(q1[i]);
      w2[i] = snoop(q2[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      busy           <= '0;
      out_valid      <= 1'b0;
      out_opcode     <= '0;
      out_func3      <= '0;
      out_func1      <= 1'b0;
      out_data1      <= '0;
      out_data2      <= '0;
      out_imm        <= '0;
      out_off        <= '0;
      out_pc         <= '0;
      out_rob_target <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && q1_wait[i] && w1[i][32]) begin
          v1[i]      <= w1[i][31:0];
          q1_wait[i] <= 1'b0;
        end
        if (busy[i] && q2_wait[i] && w2[i][32]) begin
          v2[i]      <= w2[i][31:0];
          q2_wait[i] <= 1'b0;
        end
      end
      out_valid <= has_ready;
      if (has_ready) begin
        out_opcode     <= opcode[sel_idx];
        out_func3      <= func3[sel_idx];
        out_func1      <= func1[sel_idx];
        out_data1      <= v1[sel_idx];
        out_data2      <= v2[sel_idx];
        out_imm        <= imm[sel_idx];
        out_off        <= off[sel_idx];
        out_pc         <= pc[sel_idx];
        out_rob_target <= rob_target[sel_idx];
        busy[sel_idx]  <= 1'b0;
      end
      // free_idx was non-busy before this edge, so it never collides with sel_idx
      if (in_valid && !rs_full) begin
        busy[free_idx]       <= 1'b1;
        opcode[free_idx]     <= in_opcode;
        func3[free_idx]      <= in_func3;
        func1[free_idx]      <= in_func1;
        imm[free_idx]        <= in_imm;
        off[free_idx]        <= in_off;
        pc[free_idx]         <= in_pc;
        rob_target[free_idx] <= in_rob_target;
        q1[free_idx]         <= in_rs1_tag;
        q2[free_idx]         <= in_rs2_tag;
        q1_wait[free_idx]    <= !in_rs1_rdy && !s1[32];
        q2_wait[free_idx]    <= !in_rs2_rdy && !s2[32];
        v1[free_idx]         <= in_rs1_rdy ? in_rs1_val : s1[31:0];
        v2[free_idx]         <= in_rs2_rdy ? in_rs2_val : s2[31:0];
      end
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: random and directed stimulus against a slot-level model, scoreboarded by a monitor.
module tb_alu_reservation_station;
  localparam int N = 16;
  logic        clk = 1'b0;
  logic        rst, rdy, rollback, in_valid;
  logic [6:0]  in_opcode;
  logic [2:0]  in_func3;
  logic        in_func1, in_rs1_rdy, in_rs2_rdy;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_off, in_pc;
  logic [3:0]  in_rs1_tag, in_rs2_tag, in_rob_target;
  logic        rs_full;
  logic        alu_res_valid, lsb_res_valid;
  logic [3:0]  alu_res_rob, lsb_res_rob;
  logic [31:0] alu_res_val, lsb_res_val;
  logic        out_valid;
  logic [6:0]  out_opcode;
  logic [2:0]  out_func3;
  logic        out_func1;
  logic [31:0] out_data1, out_data2, out_imm, out_off, out_pc;
  logic [3:0]  out_rob_target;

  alu_reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .in_valid(in_valid),
    .in_opcode(in_opcode), .in_func3(in_func3), .in_func1(in_func1),
    .in_rs1_rdy(in_rs1_rdy), .in_rs1_val(in_rs1_val), .in_rs1_tag(in_rs1_tag),
    .in_rs2_rdy(in_rs2_rdy), .in_rs2_val(in_rs2_val), .in_rs2_tag(in_rs2_tag),
    .in_imm(in_imm), .in_off(in_off), .in_pc(in_pc), .in_rob_target(in_rob_target),
    .rs_full(rs_full),
    .alu_res_valid(alu_res_valid), .alu_res_rob(alu_res_rob), .alu_res_val(alu_res_val),
    .lsb_res_valid(lsb_res_valid), .lsb_res_rob(lsb_res_rob), .lsb_res_val(lsb_res_val),
    .out_valid(out_valid), .out_opcode(out_opcode), .out_func3(out_func3), .out_func1(out_func1),
    .out_data1(out_data1), .out_data2(out_data2), .out_imm(out_imm), .out_off(out_off),
    .out_pc(out_pc), .out_rob_target(out_rob_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           at;
    logic [174:0] bits;
  } exp_t;
  typedef struct {
    logic        busy, w1, w2, f1;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [3:0]  t1, t2, rob;
    logic [31:0] v1, v2, imm, off, pc;
  } ent_t;

  exp_t         q[$];
  ent_t         m[N];
  logic         last_v = 1'b0;
  logic [174:0] last_bits;
  int           compared = 0, mismatched = 0, cyc = 0;

  always @(posedge clk) cyc++;

  function automatic int nbusy();
    int n = 0;
    foreach (m[i]) n += int'(m[i].busy);
    return n;
  endfunction

  function automatic logic [32:0] bcast(input logic [3:0] t);
    if (alu_res_valid && alu_res_rob == t) return {1'b1, alu_res_val};
    if (lsb_res_valid && lsb_res_rob == t) return {1'b1, lsb_res_val};
    return 33'd0;
  endfunction

  // Applies the inputs currently driven to the model, as the coming clock edge will.
  task automatic step();
    int          sel = -1, fr = -1, n;
    logic [32:0] b;
    exp_t        e;
    if (rst || rollback) begin
      foreach (m[i]) m[i].busy = 1'b0;
      last_v = 1'b0;
      return;
    end
    if (!rdy) begin
      if (last_v) begin
        e.at = cyc + 1; e.bits = last_bits; q.push_back(e);
      end
      return;
    end
    n = nbusy();
    foreach (m[i]) begin
      if (sel < 0 && m[i].busy && !m[i].w1 && !m[i].w2) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    foreach (m[i]) if (m[i].busy) begin
      b = bcast(m[i].t1);
      if (m[i].w1 && b[32]) begin m[i].v1 = b[31:0]; m[i].w1 = 1'b0; end
      b = bcast(m[i].t2);
      if (m[i].w2 && b[32]) begin m[i].v2 = b[31:0]; m[i].w2 = 1'b0; end
    end
    last_v = sel >= 0;
    if (sel >= 0) begin
      last_bits = {m[sel].opc, m[sel].f3, m[sel].f1, m[sel].v1, m[sel].v2,
                   m[sel].imm, m[sel].off, m[sel].pc, m[sel].rob};
      e.at = cyc + 1; e.bits = last_bits; q.push_back(e);
      m[sel].busy = 1'b0;
    end
    if (in_valid && n < N) begin
      m[fr].busy = 1'b1; m[fr].opc = in_opcode; m[fr].f3 = in_func3; m[fr].f1 = in_func1;
      m[fr].imm = in_imm; m[fr].off = in_off; m[fr].pc = in_pc; m[fr].rob = in_rob_target;
      m[fr].t1 = in_rs1_tag; m[fr].t2 = in_rs2_tag;
      b = bcast(in_rs1_tag);
      m[fr].w1 = !in_rs1_rdy && !b[32];
      m[fr].v1 = in_rs1_rdy ? in_rs1_val : b[31:0];
      b = bcast(in_rs2_tag);
      m[fr].w2 = !in_rs2_rdy && !b[32];
      m[fr].v2 = in_rs2_rdy ? in_rs2_val : b[31:0];
    end
  endtask

  always @(posedge clk) begin
    exp_t         e;
    logic [174:0] got;
    #2;
    got = {out_opcode, out_func3, out_func1, out_data1, out_data2, out_imm, out_off, out_pc, out_rob_target};
    compared++;
    if (rs_full !== (nbusy() == N)) begin
      mismatched++;
      $display("FAIL rs_full cycle %0d: got %b want %b", cyc, rs_full, nbusy() == N);
    end
    if (out_valid !== 1'b0) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_issue cycle %0d: got out_valid=%b with nothing expected", cyc, out_valid);
      end else begin
        e = q.pop_front();
        if (e.at != cyc || got !== e.bits || out_valid !== 1'b1) begin
          mismatched++;
          $display("FAIL issue cycle %0d (want cycle %0d): got %h want %h", cyc, e.at, got, e.bits);
        end
      end
    end
    while (q.size() != 0 && q[0].at <= cyc) begin
      compared++;
      mismatched++;
      $display("FAIL missing_issue cycle %0d: got no out_valid want %h", q[0].at, q[0].bits);
      void'(q.pop_front());
    end
  end

  task automatic tick();
    step();
    @(negedge clk);
    in_valid = 1'b0; alu_res_valid = 1'b0; lsb_res_valid = 1'b0; rollback = 1'b0;
  endtask

  task automatic op(input logic [6:0] o, input logic [2:0] f3, input logic f1,
                    input logic r1, input logic [31:0] a, input logic [3:0] t1,
                    input logic r2, input logic [31:0] b, input logic [3:0] t2,
                    input logic [3:0] rob);
    in_valid = 1'b1; in_opcode = o; in_func3 = f3; in_func1 = f1;
    in_rs1_rdy = r1; in_rs1_val = a; in_rs1_tag = t1;
    in_rs2_rdy = r2; in_rs2_val = b; in_rs2_tag = t2;
    in_rob_target = rob; in_imm = $urandom; in_off = $urandom; in_pc = $urandom;
  endtask

  task automatic bc(input logic lsb, input logic [3:0] t, input logic [31:0] v);
    if (lsb) begin lsb_res_valid = 1'b1; lsb_res_rob = t; lsb_res_val = v; end
    else begin alu_res_valid = 1'b1; alu_res_rob = t; alu_res_val = v; end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0;
    alu_res_valid = 1'b0; lsb_res_valid = 1'b0;
    alu_res_rob = '0; lsb_res_rob = '0; alu_res_val = '0; lsb_res_val = '0;
    op(7'h33, 3'd0, 1'b0, 1'b1, 0, 0, 1'b1, 0, 0, 0);
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    op(7'h33, 3'd0, 1'b0, 1'b1, 5, 0, 1'b1, 7, 0, 4'd3);
    tick(); repeat (4) tick();
    for (int l = 0; l < 2; l++) begin
      op(7'h33, 3'd0, 1'b1, 1'b0, 0, 4'd4, 1'b1, 1, 0, 4'd5);
      tick(); repeat (3) tick();
      bc(l[0], 4'd4, 32'h10);
      tick(); repeat (3) tick();
    end
    op(7'h33, 3'd7, 1'b0, 1'b1, 32'h11, 0, 1'b0, 0, 4'd9, 4'd6);
    bc(1'b1, 4'd9, 32'hABCD);
    tick(); repeat (3) tick();
    for (int i = 0; i < 17; i++) begin
      op(7'h13, 3'(i), 1'b0, 1'b0, 0, 4'd2, 1'b1, 32'(i), 0, 4'(i));
      tick();
    end
    repeat (2) tick();
    bc(1'b0, 4'd2, 32'h2222);
    tick(); repeat (20) tick();
    for (int i = 0; i < 4; i++) begin
      op(7'h63, 3'd1, 1'b0, 1'b0, 0, 4'd7, 1'b1, 0, 0, 4'(i + 8));
      tick();
    end
    op(7'h37, 3'd0, 1'b0, 1'b1, 1, 0, 1'b1, 2, 0, 4'd12);
    tick();
    op(7'h17, 3'd0, 1'b0, 1'b1, 3, 0, 1'b1, 4, 0, 4'd13);
    rollback = 1'b1;
    tick(); tick();
    bc(1'b0, 4'd7, 32'h7777);
    tick(); repeat (3) tick();
    op(7'h6F, 3'd0, 1'b0, 1'b0, 0, 4'd8, 1'b1, 0, 0, 4'd1);
    tick();
    op(7'h67, 3'd0, 1'b0, 1'b1, 9, 0, 1'b1, 10, 0, 4'd2);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bc(1'b0, 4'd8, 32'h8888);
      tick();
    end
    rdy = 1'b1;
    repeat (3) tick();
    bc(1'b1, 4'd8, 32'h9999);
    tick(); repeat (3) tick();
    for (int c = 0; c < 500; c++) begin
      rdy = $urandom_range(0, 7) != 0;
      rollback = $urandom_range(0, 63) == 0;
      if (nbusy() < N && $urandom_range(0, 2) != 0)
        op(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), $urandom, 4'($urandom),
           1'($urandom), $urandom, 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 2) == 0) bc(1'b0, 4'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) bc(1'b1, 4'($urandom), $urandom);
      tick();
    end
    rdy = 1'b1;
    repeat (6) tick();
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_expected: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
